// File: rtl/tlb_assoc_group.sv
// N-way set-associative translation buffer group: registered lookup, per-set
// round-robin replacement, parity generate/check, multi-hit detect, invalidate-all sweep.
module tlb_assoc_group #(
  parameter int unsigned WAYS   = 2,
  parameter int unsigned IDX_W  = 8,
  parameter int unsigned TAG_W  = 15,
  parameter int unsigned DATA_W = 20,
  localparam int unsigned WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic              b_clk_l,
  input  logic              reset_l,
  input  logic              lookup_h,
  input  logic [IDX_W-1:0]  index_h,
  input  logic [TAG_W-1:0]  in_tag_h,
  input  logic              fill_h,
  input  logic [DATA_W-1:0] fill_data_h,
  input  logic              par_inv_h,
  input  logic              inval_all_h,
  output logic              busy_h,
  output logic              rsp_valid_h,
  output logic              hit_h,
  output logic [WAY_W-1:0]  hit_way_h,
  output logic [DATA_W-1:0] data_out_h,
  output logic              perr_h
);

  localparam int unsigned SETS = 1 << IDX_W;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   sweep_ctr_q, sweep_ctr_d;

  logic [WAYS-1:0]    valid_q [SETS];
  logic [WAY_W-1:0]   rr_q    [SETS];
  logic [WAYS-1:0]    tpar_q  [SETS];
  logic [WAYS-1:0]    dpar_q  [SETS];
  logic [TAG_W-1:0]   tag_q   [SETS][WAYS];
  logic [DATA_W-1:0]  data_q  [SETS][WAYS];

  logic               busy_q;
  logic               rsp_valid_q, rsp_valid_d;
  logic               hit_q, hit_d;
  logic [WAY_W-1:0]   hit_way_q, hit_way_d;
  logic [DATA_W-1:0]  data_q_out, data_d_out;
  logic               perr_q, perr_d;

  logic               sweep_c;
  logic               fill_en_c;
  logic [WAYS-1:0]    rd_valid_c;
  logic [WAYS-1:0]    match_c;
  logic [WAYS-1:0]    tperr_c;
  logic [WAY_W-1:0]   match_way_c;
  logic [WAY_W-1:0]   inv_way_c;
  logic [WAY_W-1:0]   fill_way_c;
  logic [WAY_W-1:0]   rr_cur_c;
  logic [WAY_W-1:0]   rr_next_c;
  logic               any_match_c;
  logic               any_inv_c;
  logic               multi_c;
  logic               single_c;
  logic               use_rr_c;
  logic [DATA_W-1:0]  hit_data_c;
  logic               dperr_c;
  logic               tag_par_c;
  logic               data_par_c;

  assign sweep_c   = (state_q == ST_SWEEP);
  assign fill_en_c = fill_h && !sweep_c;

  // Per-way match and tag parity check on the addressed set (pre-write contents).
  always_comb begin
    rd_valid_c = valid_q[index_h];
    match_c    = '0;
    tperr_c    = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      match_c[w] = rd_valid_c[w] && (tag_q[index_h][w] == in_tag_h);
      tperr_c[w] = rd_valid_c[w] && !(^{1'b1, tag_q[index_h][w], tpar_q[index_h][w]});
    end
  end

  // Lowest-numbered matching way and lowest-numbered invalid way.
  always_comb begin
    match_way_c = '0;
    inv_way_c   = '0;
    for (int w = int'(WAYS) - 1; w >= 0; w--) begin
      if (match_c[w]) begin
        match_way_c = WAY_W'(w);
      end
      if (!rd_valid_c[w]) begin
        inv_way_c = WAY_W'(w);
      end
    end
  end

  assign any_match_c = |match_c;
  assign any_inv_c   = ~&rd_valid_c;
  assign multi_c     = |(match_c & (match_c - WAYS'(1)));
  assign single_c    = any_match_c && !multi_c;
  assign hit_data_c  = data_q[index_h][match_way_c];
  assign dperr_c     = !(^{hit_data_c, dpar_q[index_h][match_way_c]});

  // Fill way: existing match, then lowest invalid, then round-robin victim.
  assign rr_cur_c   = rr_q[index_h];
  assign rr_next_c  = (rr_cur_c == WAY_W'(WAYS - 1)) ? '0 : rr_cur_c + WAY_W'(1);
  assign use_rr_c   = !any_match_c && !any_inv_c;
  assign fill_way_c = any_match_c ? match_way_c : (any_inv_c ? inv_way_c : rr_cur_c);
  assign tag_par_c  = ~(^{1'b1, in_tag_h}) ^ par_inv_h;
  assign data_par_c = ~(^fill_data_h) ^ par_inv_h;

  always_ff @(posedge b_clk_l or negedge reset_l) begin
    if (!reset_l) begin
      state_q     <= ST_IDLE;
      sweep_ctr_q <= '0;
    end else begin
      state_q     <= state_d;
      sweep_ctr_q <= sweep_ctr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    sweep_ctr_d = sweep_ctr_q;
    case (state_q)
      ST_IDLE: begin
        sweep_ctr_d = '0;
        if (inval_all_h) begin
          state_d = ST_SWEEP;
        end
      end
      ST_SWEEP: begin
        if (sweep_ctr_q == IDX_W'(SETS - 1)) begin
          state_d     = ST_IDLE;
          sweep_ctr_d = '0;
        end else begin
          sweep_ctr_d = sweep_ctr_q + IDX_W'(1);
        end
      end
      default: begin
        state_d     = ST_IDLE;
        sweep_ctr_d = '0;
      end
    endcase
  end

  // Valid bits and replacement pointers: the sweep has priority over fills.
  always_ff @(posedge b_clk_l or negedge reset_l) begin
    if (!reset_l) begin
      for (int unsigned s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        rr_q[s]    <= '0;
      end
    end else if (sweep_c) begin
      valid_q[sweep_ctr_q] <= '0;
      rr_q[sweep_ctr_q]    <= '0;
    end else if (fill_en_c) begin
      valid_q[index_h][fill_way_c] <= 1'b1;
      if (use_rr_c) begin
        rr_q[index_h] <= rr_next_c;
      end
    end
  end

  // Tag/data storage is qualified by the valid bits, so it carries no reset.
  always_ff @(posedge b_clk_l) begin
    if (fill_en_c) begin
      tag_q[index_h][fill_way_c]  <= in_tag_h;
      data_q[index_h][fill_way_c] <= fill_data_h;
      tpar_q[index_h][fill_way_c] <= tag_par_c;
      dpar_q[index_h][fill_way_c] <= data_par_c;
    end
  end

  always_comb begin
    rsp_valid_d = lookup_h;
    hit_d       = 1'b0;
    hit_way_d   = '0;
    data_d_out  = '0;
    perr_d      = 1'b0;
    if (lookup_h && !sweep_c) begin
      perr_d = (|tperr_c) || multi_c || (single_c && dperr_c);
      if (single_c && !(|tperr_c) && !dperr_c) begin
        hit_d      = 1'b1;
        hit_way_d  = match_way_c;
        data_d_out = hit_data_c;
      end
    end
  end

  always_ff @(posedge b_clk_l or negedge reset_l) begin
    if (!reset_l) begin
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      hit_q       <= 1'b0;
      hit_way_q   <= '0;
      data_q_out  <= '0;
      perr_q      <= 1'b0;
    end else begin
      busy_q      <= (state_d == ST_SWEEP);
      rsp_valid_q <= rsp_valid_d;
      hit_q       <= hit_d;
      hit_way_q   <= hit_way_d;
      data_q_out  <= data_d_out;
      perr_q      <= perr_d;
    end
  end

  assign busy_h      = busy_q;
  assign rsp_valid_h = rsp_valid_q;
  assign hit_h       = hit_q;
  assign hit_way_h   = hit_way_q;
  assign data_out_h  = data_q_out;
  assign perr_h      = perr_q;

endmodule
